bfm_apb_responder: RTL and testbench

APB3 completer bus-functional model used as the target end of the BFM APB chain in simulation benches. It accepts transfers from one `PSEL_SC` line of the APB-to-APB bridge, backs them with a word-addressed internal memory, inserts a programmable number of wait states, and flags out-of-range accesses with `PSLVERR`. It also counts completed transfers and records protocol violations, so benches can check bridge behaviour without a real peripheral.

---
 rtl/bfm_apb_responder_pkg.sv | 20 ++
 rtl/bfm_apb_responder_mem.sv | 32 +++
 rtl/bfm_apb_responder.sv | 140 ++++++++++++++
 tb/tb_bfm_apb_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfm_apb_responder_pkg.sv
// bfm_apb_responder shared types and limits.
// Imported by the responder top and its memory.
package bfm_apb_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam int WAIT_MAX = 15;

  function automatic logic [3:0] clamp_wait(input int w);
    if (w > WAIT_MAX) return 4'(WAIT_MAX);
    if (w < 0) return 4'd0;
    return 4'(w);
  endfunction

endpackage

// File: rtl/bfm_apb_responder_mem.sv
// Single-port word memory for the APB responder.
// Synchronous write, registered read, async clear.
module bfm_apb_responder_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      // read data is only held for the PREADY cycle
      rdata <= re ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/bfm_apb_responder.sv
// APB3 completer BFM: memory-backed, programmable
// wait states, error decode, transfer/violation tracking.
module bfm_apb_responder
  import bfm_apb_responder_pkg::*;
#(
  parameter int          MEM_AW      = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] XFER_COUNT,
  output logic        PROTERR
);

  localparam logic [3:0] WAIT_LD = clamp_wait(WAIT_CYCLES);

  state_e      state;
  logic [3:0]  cnt;
  logic [31:2] addr_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic        rd_err_q;
  logic [31:0] mem_rdata;

  logic        live;
  logic        accept;
  logic        abort;
  logic        done;
  logic        viol;
  logic        chg;
  logic        cur_wr;
  logic        cur_err;
  logic [31:2] cur_addr;
  logic [31:0] cur_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  // With zero wait states the setup edge itself completes the
  // transfer, so the live bus values feed decode outside ACCESS.
  always_comb begin
    live      = (state != ACCESS);
    cur_addr  = live ? PADDR[31:2] : addr_q;
    cur_wr    = live ? PWRITE : wr_q;
    cur_wdata = live ? PWDATA : wdata_q;
    cur_err   = |cur_addr[31:MEM_AW+2];
    accept    = live && PSEL && !PENABLE;
    abort     = (state == ACCESS) && !PSEL;
    done      = (accept && (WAIT_LD == 4'd0))
             || ((state == ACCESS) && PSEL && (cnt == 4'd0));
    chg       = (PADDR[31:2] != addr_q)
             || (PWRITE != wr_q)
             || (PWDATA != wdata_q);
    viol      = abort
             || ((state == IDLE) && PSEL && PENABLE)
             || ((state == ACCESS) && PSEL && !PENABLE)
             || ((state == ACCESS) && PSEL && chg)
             || ((state == RESP) && PSEL && PENABLE && chg);
    mem_we    = done && cur_wr && !cur_err;
    mem_re    = done && !cur_wr && !cur_err;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      rd_err_q   <= 1'b0;
      XFER_COUNT <= '0;
      PROTERR    <= 1'b0;
    end else begin
      PREADY   <= done;
      PSLVERR  <= done && cur_err;
      rd_err_q <= done && cur_err && !cur_wr;
      if (viol) begin
        PROTERR <= 1'b1;
      end
      if (done) begin
        XFER_COUNT <= XFER_COUNT + 16'd1;
      end
      if (accept) begin
        addr_q  <= PADDR[31:2];
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
      end
      unique case (state)
        IDLE, RESP: begin
          if (accept && (WAIT_LD == 4'd0)) begin
            state <= RESP;
          end else if (accept) begin
            state <= ACCESS;
            cnt   <= WAIT_LD - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bfm_apb_responder_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk  (PCLK),
    .rst_n(PRESETN),
    .we   (mem_we),
    .re   (mem_re),
    .addr (cur_addr[MEM_AW+1:2]),
    .wdata(cur_wdata),
    .rdata(mem_rdata)
  );

  assign PRDATA = rd_err_q ? ERR_RDATA : mem_rdata;

endmodule

// File: tb/tb_bfm_apb_responder.sv
// Bench for bfm_apb_responder: three instances with
// 0, 3 and 2 wait states on a shared APB bus.
module tb_bfm_apb_responder;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic [2:0]  psel = '0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;

  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [15:0] xcnt [3];
  logic        proterr [3];

  int total = 0;
  int bad = 0;

  always #5 PCLK = ~PCLK;

  bfm_apb_responder #(.MEM_AW(8), .WAIT_CYCLES(0)) u0 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[0]),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .XFER_COUNT(xcnt[0]), .PROTERR(proterr[0])
  );

  bfm_apb_responder #(.MEM_AW(8), .WAIT_CYCLES(3)) u1 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[1]),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .XFER_COUNT(xcnt[1]), .PROTERR(proterr[1])
  );

  bfm_apb_responder #(.MEM_AW(8), .WAIT_CYCLES(2)) u2 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[2]),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .PSLVERR(pslverr[2]),
    .XFER_COUNT(xcnt[2]), .PROTERR(proterr[2])
  );

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    psel = '0;
    PENABLE = 1'b0;
  endtask

  // cyc counts access cycles up to and including the PREADY one
  task automatic xfer(input int k, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit b2b,
                      output logic [31:0] rd, output logic er,
                      output int cyc);
    bit got;
    @(posedge PCLK); #1;
    psel = '0;
    psel[k] = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = a;
    PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 1;
    rd = '0;
    er = 1'b0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      @(negedge PCLK);
      if (pready[k]) begin
        rd = prdata[k];
        er = pslverr[k];
        got = 1'b1;
      end else begin
        @(posedge PCLK); #1;
        cyc++;
      end
    end
    if (!got) cyc = -1;
    if (!b2b) idle();
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, " pready"}, 32'(pready[k]), 32'd0);
    chk({tag, " pslverr"}, 32'(pslverr[k]), 32'd0);
    chk({tag, " prdata"}, prdata[k], 32'd0);
    chk({tag, " count"}, 32'(xcnt[k]), 32'd0);
    chk({tag, " proterr"}, 32'(proterr[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int cyc;
    bit seen;

    tbl[0] = '{1'b1, 32'h10,  32'h1234_5678, 32'h0,          1'b0};
    tbl[1] = '{1'b0, 32'h10,  32'h0,          32'h1234_5678, 1'b0};
    tbl[2] = '{1'b1, 32'h400, 32'hA5A5_A5A5, 32'h0,          1'b1};
    tbl[3] = '{1'b0, 32'h400, 32'h0,          32'hDEAD_BEEF, 1'b1};
    tbl[4] = '{1'b0, 32'h0,   32'h0,          32'h0,          1'b0};
    tbl[5] = '{1'b0, 32'h3FC, 32'h0,          32'h0,          1'b0};

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    for (int k = 0; k < 3; k++) chk_zero(k, "reset");
    PRESETN = 1'b1;

    for (int i = 0; i < 6; i++) begin
      xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, rd, er, cyc);
      chk($sformatf("tbl%0d cyc", i), 32'(cyc), 32'd1);
      chk($sformatf("tbl%0d err", i), 32'(er), 32'(tbl[i].exp_err));
      if (!tbl[i].wr)
        chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d count", i), 32'(xcnt[0]), 32'(i + 1));
      @(negedge PCLK);
      chk($sformatf("tbl%0d rdy drop", i), 32'(pready[0]), 32'd0);
      chk($sformatf("tbl%0d err drop", i), 32'(pslverr[0]), 32'd0);
      chk($sformatf("tbl%0d rd drop", i), prdata[0], 32'd0);
    end

    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 32'(4 * i), 32'hB2B0_0000 | 32'(i), 1'b1,
           rd, er, cyc);
      chk($sformatf("b2b wr%0d cyc", i), 32'(cyc), 32'd1);
    end
    for (int i = 3; i >= 0; i--) begin
      xfer(0, 1'b0, 32'(4 * i), 32'h0, (i != 0), rd, er, cyc);
      chk($sformatf("b2b rd%0d", i), rd, 32'hB2B0_0000 | 32'(i));
      chk($sformatf("b2b rd%0d err", i), 32'(er), 32'd0);
    end
    chk("b2b count", 32'(xcnt[0]), 32'd14);
    chk("b2b proterr", 32'(proterr[0]), 32'd0);

    xfer(1, 1'b0, 32'h04, 32'h0, 1'b0, rd, er, cyc);
    chk("w3 cyc", 32'(cyc), 32'd4);
    chk("w3 rdata", rd, 32'd0);
    chk("w3 err", 32'(er), 32'd0);
    @(negedge PCLK);
    chk("w3 one cycle", 32'(pready[1]), 32'd0);
    chk("w3 proterr", 32'(proterr[1]), 32'd0);

    @(posedge PCLK); #1;
    psel = 3'b010;
    PWRITE = 1'b1;
    PADDR = 32'h08;
    PWDATA = 32'hCAFE_F00D;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PADDR = 32'h0C;
    PWDATA = 32'h1111_1111;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge PCLK);
      if (pready[1]) seen = 1'b1;
    end
    chk("chg ready", 32'(seen), 32'd1);
    idle();
    chk("chg proterr", 32'(proterr[1]), 32'd1);
    xfer(1, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, cyc);
    chk("chg latched", rd, 32'hCAFE_F00D);
    xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0, rd, er, cyc);
    chk("chg other", rd, 32'd0);

    @(posedge PCLK); #1;
    psel = 3'b100;
    PWRITE = 1'b1;
    PADDR = 32'h20;
    PWDATA = 32'h5555_AAAA;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    psel = '0;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge PCLK);
      if (pready[2]) seen = 1'b1;
    end
    chk("drop no ready", 32'(seen), 32'd0);
    chk("drop proterr", 32'(proterr[2]), 32'd1);
    chk("drop count", 32'(xcnt[2]), 32'd0);
    xfer(2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, cyc);
    chk("drop readback", rd, 32'd0);
    chk("drop rd cyc", 32'(cyc), 32'd3);
    chk("drop rd count", 32'(xcnt[2]), 32'd1);

    chk("idle-en pre", 32'(proterr[0]), 32'd0);
    @(posedge PCLK); #1;
    psel = 3'b001;
    PWRITE = 1'b1;
    PADDR = 32'h40;
    PWDATA = 32'h9999_0000;
    PENABLE = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge PCLK);
      if (pready[0]) seen = 1'b1;
    end
    idle();
    chk("idle-en ready", 32'(seen), 32'd0);
    chk("idle-en proterr", 32'(proterr[0]), 32'd1);
    chk("idle-en count", 32'(xcnt[0]), 32'd14);

    @(posedge PCLK); #1;
    psel = 3'b100;
    PWRITE = 1'b1;
    PADDR = 32'h30;
    PWDATA = 32'h7777_8888;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETN = 1'b0;
    #1;
    chk_zero(2, "midrst");
    psel = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    @(negedge PCLK);
    chk("rst count", 32'(xcnt[2]), 32'd0);
    xfer(2, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, cyc);
    chk("rst readback", rd, 32'd0);
    chk("rst rd count", 32'(xcnt[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
